// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin share of one combinational alu among NUM_REQ requesters; captures op/a/b, executes, holds result.
// Latency : grant cycle (IDLE) -> execute cycle (EXEC) -> rsp_valid from the following edge; min issue interval 3 cycles.
// Backpres: result is held in RESP until rsp_ready; no new grant is issued until the response is consumed.
//
// Ports:
//   clk, reset_n                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready          per-requester request handshake (req_ready one-hot or zero)
//   req_op/req_a/req_b           packed per-requester opcode and operands, requester i at [i*W +: W]
//   alu_srca/alu_srcb/alu_op     drive the shared alu, held from the last capture
//   alu_result                   combinational result from the alu
//   rsp_valid/rsp_ready          response handshake; rsp_id/rsp_data hold owner index and result
//   busy                         any state other than IDLE
//   op_count                     completed responses, wraps
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 2,
    parameter int CNT_WIDTH     = 16,
    localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0]   req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_b,
    output logic [DATA_WIDTH-1:0]              alu_srca,
    output logic [DATA_WIDTH-1:0]              alu_srcb,
    output logic [OPCODE_LENGTH-1:0]           alu_op,
    input  logic [DATA_WIDTH-1:0]              alu_result,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [IDW-1:0]                     rsp_id,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic                               busy,
    output logic [CNT_WIDTH-1:0]               op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                   state_q, state_d;
    logic [IDW-1:0]           rr_ptr;
    logic [IDW-1:0]           gnt_q;
    logic [IDW-1:0]           gnt_idx;
    logic [IDW-1:0]           cand;
    logic [IDW-1:0]           ptr_nxt;
    logic                     gnt_vld;
    logic                     accept;
    logic                     exec_done;
    logic                     rsp_done;
    logic [NUM_REQ-1:0]       ready_c;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign ptr_nxt = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ready_c   = '0;
        accept    = 1'b0;
        exec_done = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    ready_c[gnt_idx] = 1'b1;
                    accept           = 1'b1;
                    state_d          = EXEC;
                end
            end
            EXEC: begin
                exec_done = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State sits at IDLE during reset, so the grant is masked to keep req_ready low while reset_n is asserted.
    assign req_ready = reset_n ? ready_c : '0;
    assign busy      = (state_q != IDLE);

    // Capture registers double as the alu drive, so the alu inputs only change on a new grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            gnt_q     <= '0;
            alu_srca  <= '0;
            alu_srcb  <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                rr_ptr   <= ptr_nxt;
                gnt_q    <= gnt_idx;
                alu_op   <= req_op[gnt_idx*OPCODE_LENGTH +: OPCODE_LENGTH];
                alu_srca <= req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                alu_srcb <= req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (exec_done) begin
                rsp_data  <= alu_result;
                rsp_id    <= gnt_q;
                rsp_valid <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
